// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack: op encoding and a constant log2 helper.
// No logic of its own; no latency or flow control.
package stack_pkg;

    // op = {push, pop}
    localparam logic [1:0] OP_NONE    = 2'b00;
    localparam logic [1:0] OP_POP     = 2'b01;
    localparam logic [1:0] OP_PUSH    = 2'b10;
    localparam logic [1:0] OP_REPLACE = 2'b11;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/lifo_mem.sv
// Below-TOS storage for lifo_stack: DEPTH-1 entries, sync write, async read.
// Write lands on the clock edge; read is combinational; no backpressure.
module lifo_mem
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int ENTRIES = (1 << DEPTH_BITS) - 1;

    logic [DATA_WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // The all-ones address has no backing entry; return zero instead of X.
    assign rdata = (int'(raddr) < ENTRIES) ? mem_q[raddr] : '0;

endmodule

// File: rtl/lifo_stack.sv
// Parametrised LIFO with registered TOS, replace op, occupancy and sticky error flags.
// Ops take effect on the sampling edge; refused push/pop sets overflow/underflow instead of stalling.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 4,
    parameter int AFULL_LVL  = (1 << DEPTH_BITS) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DEPTH_BITS:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH   = 1 << DEPTH_BITS;
    localparam int                CNT_W   = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_C = CNT_W'(AFULL_LVL);

    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] tos_q, tos_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  mem_we;
    logic [DEPTH_BITS-1:0] mem_waddr, mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [1:0]            op;
    logic                  is_empty, is_full;

    assign op       = {push, pop};
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // Old TOS goes to slot count-1; NOS is read from slot count-2.
    assign mem_waddr = count_q[DEPTH_BITS-1:0] - DEPTH_BITS'(1);
    assign mem_raddr = count_q[DEPTH_BITS-1:0] - DEPTH_BITS'(2);

    always_comb begin
        count_d = count_q;
        tos_d   = tos_q;
        ovf_d   = ovf_q & ~clr_err;
        udf_d   = udf_q & ~clr_err;
        mem_we  = 1'b0;
        if (flush) begin
            count_d = '0;
            tos_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = !is_empty;
                        tos_d   = data_in;
                        count_d = count_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        udf_d = 1'b1;
                    end else if (count_q == CNT_W'(1)) begin
                        tos_d   = '0;
                        count_d = '0;
                    end else begin
                        tos_d   = mem_rdata;
                        count_d = count_q - CNT_W'(1);
                    end
                end
                OP_REPLACE: begin
                    tos_d = data_in;
                    if (is_empty) begin
                        count_d = CNT_W'(1);
                        udf_d   = 1'b1;
                    end
                end
                OP_NONE: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    lifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && rst_n),
        .waddr (mem_waddr),
        .wdata (tos_q),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign data_out    = tos_q;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= AFULL_C);
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack (DEPTH=4, AFULL_LVL=3) against a queue-based reference stack.
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_out;
    logic [2:0] count;
    logic       empty, full, almost_full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic [2:0] cnt;
        logic       emp, ful, afl, ovf, udf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    lifo_stack #(.DATA_WIDTH(8), .DEPTH_BITS(2), .AFULL_LVL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .push        (push),
        .pop         (pop),
        .flush       (flush),
        .clr_err     (clr_err),
        .data_out    (data_out),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic ps, input logic pp,
                              input logic [7:0] d, input logic fl, input logic ce);
        logic set_o, set_u;
        set_o = 1'b0;
        set_u = 1'b0;
        if (!r || fl) begin
            model.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (ps && pp) begin
                if (model.size() == 0) begin
                    model.push_back(d);
                    set_u = 1'b1;
                end else begin
                    model[model.size()-1] = d;
                end
            end else if (ps) begin
                if (model.size() == 4) set_o = 1'b1;
                else model.push_back(d);
            end else if (pp) begin
                if (model.size() == 0) set_u = 1'b1;
                else void'(model.pop_back());
            end
            m_ovf = (m_ovf && !ce) || set_o;
            m_udf = (m_udf && !ce) || set_u;
        end
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got size %0d exp >0", exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (data_out === e.data) else begin
                errors++; $error("FAIL %s data_out got %h exp %h", e.tag, data_out, e.data);
            end
            checks++;
            assert (count === e.cnt) else begin
                errors++; $error("FAIL %s count got %0d exp %0d", e.tag, count, e.cnt);
            end
            checks++;
            assert (empty === e.emp) else begin
                errors++; $error("FAIL %s empty got %b exp %b", e.tag, empty, e.emp);
            end
            checks++;
            assert (full === e.ful) else begin
                errors++; $error("FAIL %s full got %b exp %b", e.tag, full, e.ful);
            end
            checks++;
            assert (almost_full === e.afl) else begin
                errors++; $error("FAIL %s almost_full got %b exp %b", e.tag, almost_full, e.afl);
            end
            checks++;
            assert (overflow === e.ovf) else begin
                errors++; $error("FAIL %s overflow got %b exp %b", e.tag, overflow, e.ovf);
            end
            checks++;
            assert (underflow === e.udf) else begin
                errors++; $error("FAIL %s underflow got %b exp %b", e.tag, underflow, e.udf);
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic ps, input logic pp,
                        input logic [7:0] d, input logic fl, input logic ce);
        exp_t e;
        int   n;
        rst_n   = r;
        push    = ps;
        pop     = pp;
        data_in = d;
        flush   = fl;
        clr_err = ce;
        model_step(r, ps, pp, d, fl, ce);
        n     = model.size();
        e.tag = tag;
        e.data = (n > 0) ? model[n-1] : 8'h00;
        e.cnt = 3'(n);
        e.emp = (n == 0);
        e.ful = (n == 4);
        e.afl = (n >= 3);
        e.ovf = m_ovf;
        e.udf = m_udf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        @(negedge clk);
        // reset dominates a concurrent push
        step("reset",     1'b0, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        // fill, then overflow
        step("push11",    1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        step("push22",    1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
        step("push33",    1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
        step("push44",    1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
        step("push55_ov", 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
        // drain, then underflow and clear
        for (int i = 0; i < 5; i++)
            step($sformatf("pop%0d", i), 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("clr_err",   1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        // replace in the middle
        step("pushA1",    1'b1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0);
        step("pushA2",    1'b1, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b0);
        step("replB0",    1'b1, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
        step("pop_to_A1", 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("pop_to_0",  1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        // replace when full, replace when empty
        for (int i = 1; i <= 4; i++)
            step($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("replCC_full", 1'b1, 1'b1, 1'b1, 8'hCC, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("repl7E_empty", 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
        // flush beats a push; error set beats clr_err
        step("push_e1",   1'b1, 1'b1, 1'b0, 8'hE1, 1'b0, 1'b0);
        step("push_e2",   1'b1, 1'b1, 1'b0, 8'hE2, 1'b0, 1'b0);
        step("flush",     1'b1, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0);
        step("pop_clr",   1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step("clr_only",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        // overflow with clr_err in the same cycle keeps the flag
        for (int i = 0; i < 4; i++)
            step($sformatf("refill%0d", i), 1'b1, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        step("ovf_clr",   1'b1, 1'b1, 1'b0, 8'h6F, 1'b0, 1'b1);
        step("pop_nos",   1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        // reset drops an in-flight pop; memory slots are then reused
        step("reset_pop", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("push_d1",   1'b1, 1'b1, 1'b0, 8'hD1, 1'b0, 1'b0);
        step("push_d2",   1'b1, 1'b1, 1'b0, 8'hD2, 1'b0, 1'b0);
        step("pop_d1",    1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        step("idle",      1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
